// File: rtl/load_wb_unit.sv
// Load/writeback unit: issues one word-aligned data-memory read per load, extracts
// and extends the addressed byte/half/word, and writes it to the register file.
module load_wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_req_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic [4:0]  waddr,
  output logic        wen,
  output logic [31:0] wdata,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  // LB/LBU can never be misaligned; reserved types behave as LW.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] lo);
    case (t)
      3'd0, 3'd1: return 1'b0;
      3'd2, 3'd3: return lo[0];
      default:    return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (t)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {24'h0, b};
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      type_q   <= 3'd0;
      addr_q   <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          type_d  = req_type;
          addr_d  = req_addr;
          rd_d    = req_rd;
          state_d = misaligned(req_type, req_addr[1:0]) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        // Data arriving alongside the ack is deliberately dropped.
        if (mem_req_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rdata_valid) begin
          result_d = extract(type_q, addr_q[1:0], mem_rdata);
          state_d  = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state and latched fields only; req_ready is also gated by reset.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = 32'd0;
    waddr     = 5'd0;
    wen       = 1'b0;
    wdata     = 32'd0;
    load_err  = 1'b0;
    case (state_q)
      S_IDLE: req_ready = rst;
      S_REQ: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
      end
      S_WB: begin
        waddr = rd_q;
        wen   = (rd_q != 5'd0);
        wdata = result_q;
      end
      S_ERR:   load_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_wb_unit.sv
// Bench for load_wb_unit: directed vector table, random loads against an
// arithmetic reference model, and a mid-transaction reset sequence.
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_req_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rdata_valid = 1'b0;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] wdata;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  load_wb_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_rd(req_rd),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_req_ack(mem_req_ack),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .waddr(waddr), .wen(wen), .wdata(wdata), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [4:0]  rd;
    logic [31:0] d;
    int          ack_dly;
    int          dat_dly;
    bit          noise;
    bit          exp_err;
    logic [31:0] exp_wd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: size/sign from the opcode, alignment by modulo, lane by shift.
  function automatic void ref_load(input int t, input logic [31:0] a, input logic [31:0] d,
                                   output bit err, output logic [31:0] v);
    longint size, off, x, lim;
    bit sgn;
    size = (t <= 1) ? 1 : (t <= 3) ? 2 : 4;
    sgn  = (t == 0) || (t == 2);
    err  = (longint'(a) % size) != 0;
    off  = (longint'(a) % 4) - ((longint'(a) % 4) % size);
    lim  = longint'(1) << (8 * size);
    x    = (longint'(d) >> (8 * off)) % lim;
    if (sgn && x >= lim / 2) x = x - lim;
    v = x[31:0];
  endfunction

  // Runs one load: handshake, then serves memory with the given delays.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, n_read, n_wen, n_err, addr_bad, ready_cyc, wait_cnt;
    bit acked, got_data, done;
    logic [31:0] got_wd;
    logic [4:0]  got_wa;
    n_read = 0; n_wen = 0; n_err = 0; addr_bad = 0; ready_cyc = -1; wait_cnt = 0;
    acked = 0; got_data = 0; done = 0; got_wd = 'x; got_wa = 'x;
    @(negedge clk);
    chk({tag, " idle_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_type = v.t; req_addr = v.a; req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    cyc = 1;
    while (!done && cyc <= 60) begin
      if (mem_read) begin
        n_read++;
        if (mem_addr !== (v.a & ~32'd3)) addr_bad++;
      end
      if (wen) begin
        n_wen++; got_wd = wdata; got_wa = waddr;
      end
      if (load_err) n_err++;
      if (req_ready) begin
        ready_cyc = cyc; done = 1;
      end
      mem_req_ack = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = ~v.d;
      if (acked && !got_data) begin
        wait_cnt++;
        if (wait_cnt > v.dat_dly) begin
          mem_rdata_valid = 1'b1; mem_rdata = v.d; got_data = 1;
        end
      end
      if (mem_read) begin
        if (v.noise) mem_rdata_valid = 1'b1;
        if (n_read == v.ack_dly + 1) begin
          mem_req_ack = 1'b1; acked = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_req_ack = 1'b0; mem_rdata_valid = 1'b0;
    chk({tag, " ready_cycle"}, ready_cyc, v.exp_err ? 2 : v.ack_dly + v.dat_dly + 4);
    chk({tag, " read_cycles"}, n_read, v.exp_err ? 0 : v.ack_dly + 1);
    chk({tag, " err_pulses"}, n_err, v.exp_err ? 1 : 0);
    chk({tag, " wen_cycles"}, n_wen, (!v.exp_err && v.rd != 0) ? 1 : 0);
    chk({tag, " addr_bad"}, addr_bad, 0);
    if (!v.exp_err && v.rd != 0) begin
      chk({tag, " wdata"}, got_wd, v.exp_wd);
      chk({tag, " waddr"}, got_wa, v.rd);
    end
  endtask

  task automatic chk_all_zero(input string tag, input logic exp_ready);
    chk({tag, " req_ready"}, req_ready, exp_ready);
    chk({tag, " mem_read"}, mem_read, 1'b0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " wen"}, wen, 1'b0);
    chk({tag, " waddr"}, waddr, 5'd0);
    chk({tag, " wdata"}, wdata, 32'd0);
    chk({tag, " load_err"}, load_err, 1'b0);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t rv;
    bit   e;
    logic [31:0] w;

    tbl[0] = '{3'd0, 32'h0000_1003, 5'd5,  32'h80FF_1234, 0, 0, 0, 0, 32'hFFFF_FF80};
    tbl[1] = '{3'd3, 32'h0000_2002, 5'd6,  32'h9ABC_0000, 0, 0, 0, 0, 32'h0000_9ABC};
    tbl[2] = '{3'd2, 32'h0000_2002, 5'd7,  32'h9ABC_0000, 0, 0, 0, 0, 32'hFFFF_9ABC};
    tbl[3] = '{3'd4, 32'h0000_3001, 5'd8,  32'h1111_1111, 0, 0, 0, 1, 32'h0};
    tbl[4] = '{3'd4, 32'h0000_4000, 5'd0,  32'hDEAD_BEEF, 0, 0, 0, 0, 32'hDEAD_BEEF};
    tbl[5] = '{3'd4, 32'h0000_6004, 5'd31, 32'h1234_5678, 3, 2, 0, 0, 32'h1234_5678};
    tbl[6] = '{3'd1, 32'h0000_1001, 5'd9,  32'h0000_8000, 1, 0, 1, 0, 32'h0000_0080};
    tbl[7] = '{3'd6, 32'h0000_5002, 5'd10, 32'h0, 0, 0, 0, 1, 32'h0};
    tbl[8] = '{3'd2, 32'h0000_1001, 5'd11, 32'h0, 0, 0, 0, 1, 32'h0};
    tbl[9] = '{3'd7, 32'hFFFF_FFF8, 5'd12, 32'hCAFE_F00D, 0, 1, 1, 0, 32'hCAFE_F00D};

    #2;
    chk_all_zero("reset", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("post_reset", 1'b1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abandoned load: reset lands in WAIT, late data must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'd4; req_addr = 32'h0000_7000; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstseq mem_read", mem_read, 1'b1);
    mem_req_ack = 1'b1;
    @(negedge clk);
    mem_req_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("rstseq in_reset", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rstseq ready", req_ready, 1'b1);
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk_all_zero("rstseq after", 1'b1);

    for (int i = 0; i < 40; i++) begin
      rv.t  = 3'($urandom_range(0, 7));
      rv.a  = $urandom;
      rv.rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      rv.d  = $urandom;
      rv.ack_dly = $urandom_range(0, 3);
      rv.dat_dly = $urandom_range(0, 3);
      rv.noise   = $urandom_range(0, 1);
      ref_load(int'(rv.t), rv.a, rv.d, e, w);
      rv.exp_err = e;
      rv.exp_wd  = w;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
